// File: rtl/mult_div_unit_if.sv
// Handshake/data bundle between the execute stage and the multiply/divide unit.
// The pipeline side is the master; the unit itself is the slave.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, A, B, flush, wr_hi, wr_lo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, A, B, flush, wr_hi, wr_lo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: one shift/add (multiply)
// or restoring-subtract (divide) step per cycle over a shared 2*WIDTH register.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  mult_div_unit_if.slave        bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;

  state_e             state_q;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q;
  logic               neg_q;
  logic               rem_neg_q;
  logic               zero_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  logic               signed_op;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum_d;
  logic [2*WIDTH-1:0] mul_next_d;
  logic [WIDTH:0]     div_diff_d;
  logic [2*WIDTH-1:0] div_next_d;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi_d;
  logic [WIDTH-1:0]   res_lo_d;

  always_comb begin
    signed_op = ~bus.op[0];
    abs_a     = (signed_op && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    abs_b     = (signed_op && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    // Multiply: add multiplicand into the upper half when the LSB is set, then shift right.
    mul_sum_d  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? opnd_q : '0)};
    mul_next_d = {mul_sum_d, prod_q[WIDTH-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    div_diff_d = prod_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    div_next_d = div_diff_d[WIDTH] ? {prod_q[2*WIDTH-2:0], 1'b0}
                                   : {div_diff_d[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};

    prod_neg = -prod_q;
    quo      = prod_q[WIDTH-1:0];
    rem      = prod_q[2*WIDTH-1:WIDTH];
    res_hi_d = neg_q ? prod_neg[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
    res_lo_d = neg_q ? prod_neg[WIDTH-1:0] : prod_q[WIDTH-1:0];
    if (is_div_q) begin
      res_hi_d = rem_neg_q ? -rem : rem;
      res_lo_d = zero_q ? '1 : (neg_q ? -quo : quo);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      prod_q    <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      zero_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.wr_hi) hi_q <= bus.wdata;
      if (bus.wr_lo) lo_q <= bus.wdata;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            is_div_q  <= bus.op[1];
            neg_q     <= signed_op && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            rem_neg_q <= signed_op && bus.A[WIDTH-1];
            zero_q    <= (bus.B == '0);
            prod_q    <= {{WIDTH{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
            opnd_q    <= bus.op[1] ? abs_b : abs_a;
            count_q   <= CW'(WIDTH - 1);
            busy_q    <= 1'b1;
            state_q   <= CALC;
          end
        end
        CALC: begin
          if (bus.flush) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            prod_q <= is_div_q ? div_next_d : mul_next_d;
            if (count_q == '0) begin
              state_q <= FINISH;
            end else begin
              count_q <= count_q - 1'b1;
            end
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
          // The commit overrides any MTHI/MTLO landing on the same edge.
          if (!bus.flush) begin
            hi_q   <= res_hi_d;
            lo_q   <= res_lo_d;
            done_q <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: latency, sign handling, corner
// divides, flush, reset and MTHI/MTLO interplay with the commit.
module tb_mult_div_unit;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives start in the current cycle (cycle 0) and ends in cycle 34.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int ign_cyc,
                        input int mthi_cyc, input bit wrlo_fin);
    logic window_ok;
    window_ok  = 1'b1;
    bus.start  = 1'b1;
    bus.op     = o;
    bus.A      = a;
    bus.B      = b;
    tick();
    for (int cyc = 1; cyc <= 32; cyc++) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) window_ok = 1'b0;
      if (cyc == mthi_cyc + 1 && mthi_cyc != 0)
        check_eq({tag, "_mthi_seen"}, {32'h0, bus.hi}, 64'h0000_0000_DEAD_BEEF);
      bus.start = (cyc == ign_cyc);
      if (cyc == ign_cyc) begin
        bus.op = 2'b11;
        bus.A  = 32'd5;
        bus.B  = 32'd6;
      end
      bus.wr_hi = (cyc == mthi_cyc);
      bus.wdata = 32'hDEAD_BEEF;
      tick();
    end
    bus.start = 1'b0;
    bus.wr_hi = 1'b0;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) window_ok = 1'b0;
    check_eq({tag, "_busy_window"}, {63'h0, window_ok}, 64'h1);
    if (wrlo_fin) begin
      bus.wr_lo = 1'b1;
      bus.wdata = 32'h0000_5555;
    end
    tick();
    bus.wr_lo = 1'b0;
    check_eq({tag, "_busy34"}, {63'h0, bus.busy}, 64'h0);
    check_eq({tag, "_done34"}, {63'h0, bus.done}, 64'h1);
    check_eq({tag, "_hi"}, {32'h0, bus.hi}, {32'h0, exp_hi});
    check_eq({tag, "_lo"}, {32'h0, bus.lo}, {32'h0, exp_lo});
    $display("op %s hi=%h lo=%h", tag, bus.hi, bus.lo);
  endtask

  initial begin
    logic ok;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.A     = '0;
    bus.B     = '0;
    bus.flush = 1'b0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    bus.wdata = '0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_busy", {63'h0, bus.busy}, 64'h0);
    check_eq("rst_done", {63'h0, bus.done}, 64'h0);
    check_eq("rst_hilo", {bus.hi, bus.lo}, 64'h0);

    // start together with flush in IDLE must not launch
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = 2'b01;
    bus.A     = 32'd3;
    bus.B     = 32'd4;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check_eq("start_flush_idle", {63'h0, bus.busy}, 64'h0);

    // reset in cycle 10 of a MULTU
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.A     = 32'd5;
    bus.B     = 32'd6;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst_busy", {63'h0, bus.busy}, 64'h0);
    check_eq("midrst_done", {63'h0, bus.done}, 64'h0);
    check_eq("midrst_hilo", {bus.hi, bus.lo}, 64'h0);
    $display("op reset_mid_calc busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);

    run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0, 1'b0);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5, 0, 1'b0);
    tick();
    check_eq("ignored_start_idle", {62'h0, bus.busy, bus.done}, 64'h0);
    run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 1'b0);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0, 10, 1'b0);
    run_op("divu_by0", 2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 0, 0, 1'b1);
    run_op("div_by0_neg", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0, 0, 1'b0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, 0, 1'b0);

    // MTLO, then flush a DIV in cycle 20
    bus.wr_lo = 1'b1;
    bus.wdata = 32'hAAAA_5555;
    tick();
    bus.wr_lo = 1'b0;
    check_eq("mtlo", {32'h0, bus.lo}, 64'h0000_0000_AAAA_5555);
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.A     = 32'd1000;
    bus.B     = 32'd3;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check_eq("flush_busy", {63'h0, bus.busy}, 64'h0);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
      tick();
    end
    check_eq("flush_no_done", {63'h0, ok}, 64'h1);
    check_eq("flush_lo", {32'h0, bus.lo}, 64'h0000_0000_AAAA_5555);
    check_eq("flush_hi", {32'h0, bus.hi}, 64'h0);
    $display("op div_flush busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide controller for the MIPS execute stage; owns the HI/LO register pair.
- Sequences a shared shift/add-subtract datapath over WIDTH iterations.
- Serves MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Drives busy so the pipeline stalls MFHI/MFLO and back-to-back mult/div ops until the result is committed.

Parameters:
- WIDTH, 32, operand width; also the iteration count.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  launch the operation on op/A/B; honoured only when idle.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- A  input  WIDTH  rs operand (multiplicand/dividend); sampled with start.
- B  input  WIDTH  rt operand (multiplier/divisor); sampled with start.
- flush  input  1  cancel the in-flight operation (exception/branch squash).
- wr_hi  input  1  MTHI write strobe.
- wr_lo  input  1  MTLO write strobe.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse: HI/LO just committed.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0. Reset dominates every other input, including mid-operation.
- States: IDLE, CALC, FINISH.
- IDLE:
  - start=1 (cycle 0) latches |A|, |B|, result sign flags and op, then moves to CALC.
  - Sign handling: for MULT/DIV, magnitudes are taken from two's complement. For MULTU/DIVU, operands are used raw.
- CALC: runs exactly WIDTH cycles (cycles 1..32), one iteration per cycle; the counter counts WIDTH-1 down to 0. Then moves to FINISH.
  - Multiply: shift-add on a 2*WIDTH product register.
  - Divide: restoring division producing one quotient bit per cycle.
- FINISH (cycle 33): sign fix-up. At the closing edge it writes the results and moves to IDLE.
  - Multiply: {hi,lo} = product, negated if the operand signs differ (signed ops only).
  - Divide: lo = quotient, negated if signs differ; hi = remainder, carrying the dividend's sign.
- done=1 in cycle 34 only, with the new hi/lo visible. busy=0 in cycle 34, and a new start is accepted in cycle 34.
- busy=1 exactly in cycles 1..33; busy is registered.
- Start rules:
  - start while busy: ignored; no state change.
  - start and flush in the same IDLE cycle: flush wins; no launch.
- Flush:
  - flush in CALC or FINISH: return to IDLE at the next edge. hi/lo unchanged, no done pulse.
  - flush in IDLE has no effect.
- Divide by zero (B=0, DIV or DIVU): full latency; lo=all ones, hi=A (raw, unsigned or signed).
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO:
  - wr_hi/wr_lo update hi/lo at the next edge in any state.
  - In the same cycle as a FINISH commit, the commit wins.
  - A write during CALC is overwritten by the later commit.
  - wr_hi and wr_lo together both write wdata.
- hi/lo are registered outputs and change only on a reset, write or commit edge.

Test Plan:
- Reset mid-CALC (start MULTU, assert reset in cycle 10) -> next cycle busy=0, done=0, hi=lo=0; a new start is accepted the following cycle.
- MULT A=0xFFFFFFFD (-3), B=7 -> busy cycles 1..33, done in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; a start in cycle 5 with other operands is ignored.
- DIV A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU A=100, B=7 -> lo=14, hi=2.
- DIVU A=0x1234, B=0 -> lo=0xFFFFFFFF, hi=0x1234.
- DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Flush in cycle 20 of a DIV after MTLO 0xAAAA5555 -> no done; lo stays 0xAAAA5555; busy=0 next cycle.
- MTHI during CALC -> overwritten by the commit.
- wr_lo in the FINISH cycle -> commit value wins.
